// File: rtl/reg_dump.sv
// Byte-stream dump of a range of register-file entries through the debug read port.
// Each register is sent as a header byte carrying its index, then its N/8 data bytes MSB first.
module reg_dump #(
  parameter int N = 32,
  parameter int L = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [4:0]   lo,
  input  logic [4:0]   hi,
  output logic [4:0]   checka,
  input  logic [N-1:0] check,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam int NB = N / 8;
  localparam int CW = 4;

  typedef enum logic [2:0] {IDLE, ADDR, HDR, SEND, FIN} state_t;

  state_t         state;
  logic [4:0]     idx;
  logic [4:0]     hi_reg;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   shreg;
  logic [N-1:0]   shreg_shift;
  logic           last_reg;
  logic           empty;
  logic           hs;

  assign shreg_shift = shreg << 8;
  assign last_reg    = (idx == hi_reg) || ({1'b0, idx} == 6'(L - 1));
  assign empty       = (lo > hi) || ({1'b0, lo} >= 6'(L));
  assign hs          = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      hi_reg    <= '0;
      cnt       <= '0;
      shreg     <= '0;
      checka    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            hi_reg <= hi;
            idx    <= lo;
            checka <= lo;
            busy   <= 1'b1;
            if (empty) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= ADDR;
            end
          end
        end
        ADDR: begin
          shreg     <= check;
          cnt       <= '0;
          out_valid <= 1'b1;
          out_data  <= {3'b000, idx};
          state     <= HDR;
        end
        HDR: begin
          if (hs) begin
            out_data <= shreg[N-1 -: 8];
            state    <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            shreg <= shreg_shift;
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(NB - 1)) begin
              // Last data byte of this register accepted.
              out_valid <= 1'b0;
              if (last_reg) begin
                state <= FIN;
                done  <= 1'b1;
              end else begin
                idx    <= idx + 5'd1;
                checka <= idx + 5'd1;
                state  <= ADDR;
              end
            end else begin
              out_data <= shreg_shift[N-1 -: 8];
            end
          end
        end
        FIN: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: directed scenarios plus randomized dumps,
// each compared against a byte-list model built from the register contents.
module tb_reg_dump;
  localparam int N  = 32;
  localparam int L  = 32;
  localparam int NB = N / 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [4:0]   lo;
  logic [4:0]   hi;
  logic [4:0]   checka;
  logic [N-1:0] check;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;

  logic [N-1:0] regs [32];

  reg_dump #(.N(N), .L(L)) dut (
    .clk(clk), .reset(reset), .start(start), .lo(lo), .hi(hi),
    .checka(checka), .check(check), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  assign check = regs[checka];
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ready pattern: 0 = always 1, 1 = random, 2 = repeating 1,0,0,1
  int   ready_mode = 0;
  int   pat_i = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
    endcase
    pat_i++;
  end

  logic [7:0] q_got [$];
  int         done_cnt = 0;
  int         busy_cnt = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(stall_data));
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (out_valid && out_ready) q_got.push_back(out_data);
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  function automatic void build_expected(input int l, input int h, output logic [7:0] e [$]);
    int top;
    e = {};
    if (l > h || l >= L) return;
    top = (h < L - 1) ? h : L - 1;
    for (int k = l; k <= top; k++) begin
      e.push_back(8'(k));
      for (int b = NB - 1; b >= 0; b--) e.push_back(8'((regs[k] >> (8 * b)) & 'hFF));
    end
  endfunction

  task automatic pulse_start(input int l, input int h);
    @(posedge clk); #1;
    start = 1'b1; lo = 5'(l); hi = 5'(h);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // poke_at: after this many bytes seen, write regs[poke_idx]=poke_val (negative disables)
  // restart_at: cycle count at which a stray start is pulsed mid-dump (negative disables)
  task automatic run_dump(input string name, input int l, input int h, input int mode,
                          input int poke_at, input int poke_idx, input logic [N-1:0] poke_val,
                          input int restart_at);
    logic [7:0] exp_q [$];
    int nregs;
    int cyc;
    build_expected(l, h, exp_q);
    nregs = exp_q.size() / (1 + NB);
    ready_mode = mode;
    pat_i = 0;
    @(negedge clk);
    q_got = {};
    done_cnt = 0;
    busy_cnt = 0;
    pulse_start(l, h);
    cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (poke_at >= 0 && q_got.size() >= poke_at) begin
        regs[poke_idx] = poke_val;
        poke_at = -1;
      end
      if (cyc == restart_at) begin
        start = 1'b1; lo = 5'd7; hi = 5'd8;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end
    end
    if (done_cnt == 0) chk({name, "_timeout"}, 64'd0, 64'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({name, "_nbytes"}, 64'(q_got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < q_got.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), 64'(q_got[i]), 64'(exp_q[i]));
    chk({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({name, "_busy_after"}, 64'(busy), 64'd0);
    if (mode == 0) chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(nregs * (2 + NB) + 1));
    $display("dump %s lo=%0d hi=%0d mode=%0d bytes=%0d busy=%0d", name, l, h, mode, q_got.size(), busy_cnt);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; lo = '0; hi = '0; out_ready = 1'b1;
    for (int k = 0; k < 32; k++) regs[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_checka", 64'(checka), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    regs[3] = 32'hDEADBEEF;
    run_dump("single", 3, 3, 0, -1, 0, '0, -1);

    for (int k = 0; k < 32; k++) regs[k] = 32'(k) * 32'h01010101;
    run_dump("full", 0, 31, 0, -1, 0, '0, 20);

    run_dump("empty", 5, 2, 0, -1, 0, '0, -1);

    regs[1] = 32'hA1B2C3D4; regs[2] = 32'h55667788;
    run_dump("stall", 1, 2, 2, -1, 0, '0, -1);

    regs[1] = 32'h11111111;
    run_dump("capture", 1, 1, 0, 2, 1, 32'h22222222, -1);

    // Reset in the middle of a full dump
    for (int k = 0; k < 32; k++) regs[k] = 32'(k) * 32'h01010101;
    ready_mode = 0;
    @(negedge clk);
    q_got = {};
    pulse_start(0, 31);
    for (int c = 0; c < 200 && q_got.size() < 3; c++) @(posedge clk);
    chk("rst_mid_reached", 64'(q_got.size()), 64'd3);
    #1;
    reset = 1'b1;
    done_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_no_done", 64'(done_cnt), 64'd0);
    chk("rst_mid_idle", 64'(busy), 64'd0);
    run_dump("restart", 0, 0, 0, -1, 0, '0, -1);

    for (int t = 0; t < 12; t++) begin
      int l, h, m;
      for (int k = 0; k < 32; k++) regs[k] = N'($urandom);
      l = $urandom_range(0, 31);
      h = $urandom_range(0, 31);
      if (t % 3 == 0) h = l + $urandom_range(0, 4);
      if (h > 31) h = 31;
      m = $urandom_range(0, 2);
      run_dump($sformatf("rnd%0d", t), l, h, m, -1, 0, '0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 SHALL have parameter N, default 32, meaning register data width in bits; N SHALL be a multiple of 8, 8..64.
REQ-002 SHALL have parameter L, default 32, meaning number of registers addressable through the check port, L <= 32.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 SHALL have port lo  input  5  first register index of the dump, latched on accepted start.
REQ-007 SHALL have port hi  input  5  last register index of the dump, latched on accepted start.
REQ-008 SHALL have port checka  output  5  register-file debug read address.
REQ-009 SHALL have port check  input  N  register-file debug read data, combinational from checka.
REQ-010 SHALL have port out_data  output  8  byte stream data.
REQ-011 SHALL have port out_valid  output  1  out_data holds a valid byte.
REQ-012 SHALL have port out_ready  input  1  sink accepts byte when out_valid & out_ready at a rising edge.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of a dump.

Function
REQ-015 SHALL implement states IDLE, ADDR, HDR, SEND, FIN.
REQ-016 IDLE: start=1 SHALL latch lo/hi, set idx=lo, drive checka=lo, go to ADDR; if lo>hi or lo>=L, go to FIN instead (empty dump, zero bytes).
REQ-017 ADDR (exactly 1 cycle): SHALL capture check into an N-bit shift register, clear byte counter, go to HDR.
REQ-018 HDR: SHALL drive out_valid=1, out_data={3'b000,idx}; on handshake go to SEND.
REQ-019 SEND: SHALL drive out_valid=1, out_data=shift register bits [N-1:N-8] (MSB byte first); on handshake shift left 8 and increment counter.
REQ-020 After handshake of byte N/8 of a register: if idx==hi or idx==L-1 go to FIN, else idx=idx+1, checka=idx+1, go to ADDR.
REQ-021 FIN (1 cycle): SHALL assert done=1, out_valid=0, then go to IDLE.
REQ-022 out_data and out_valid SHALL be held stable while out_valid=1 and out_ready=0; no byte dropped or duplicated.
REQ-023 out_valid SHALL be 0 in IDLE, ADDR, FIN; out_valid SHALL not depend combinationally on out_ready.
REQ-024 Bytes per dump SHALL be (min(hi,L-1)-lo+1)*(1+N/8); for N=32, lo=0, hi=31: 160 bytes.
REQ-025 Captured word SHALL be the check value in the ADDR cycle; register-file writes after ADDR SHALL not alter bytes of that register.
REQ-026 checka SHALL be registered and constant from ADDR through the last SEND byte of that register.
REQ-027 start while busy=1 SHALL be ignored, lo/hi not relatched.
REQ-028 Minimum cycles per register with out_ready tied 1 SHALL be 2+N/8 (ADDR, HDR, N/8 SEND).

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE, checka=0, out_data=0, out_valid=0, busy=0, done=0, idx=0, counter=0, shift register=0.
REQ-030 reset SHALL override start and any in-flight handshake in the same cycle; a dump interrupted by reset SHALL not resume or pulse done.

Verification
REQ-031 N=32, lo=3, hi=3, reg3=0xDEADBEEF, out_ready=1 -> bytes 0x03,0xDE,0xAD,0xBE,0xEF; done 1 cycle after 0xEF; busy 7 cycles total.
REQ-032 lo=0, hi=31, reg k = k*0x01010101, out_ready=1 -> 160 bytes, header k followed by k,k,k,k for k=0..31; single done pulse.
REQ-033 lo=5, hi=2 -> zero bytes, done pulses in cycle 2 after start, busy high exactly 1 cycle.
REQ-034 lo=1, hi=2, out_ready toggled 1,0,0,1 pattern -> same 10 byte sequence as out_ready=1, out_data stable across every stall.
REQ-035 reg1=0x11111111 captured, then register file writes reg1=0x22222222 during SEND -> stream carries 0x11 bytes for reg1.
REQ-036 reset asserted after third byte of 0..31 dump -> next cycle out_valid=0, busy=0, no done; new start lo=0 restarts with header 0x00.
